// File: rtl/conv2d3x3_out_sink.sv
// Receive-side sink for the Conv2D3x3 output stream: captures one output feature map,
// then holds it for a random-access reader until the frame is acknowledged.
module conv2d3x3_out_sink #(
    parameter int OUT_HEIGHT = 3,
    parameter int OUT_WIDTH  = 2,
    parameter int FILTERS    = 8,
    parameter int WORD_WIDTH = 8,
    parameter int BEAT_WORDS = 4,
    parameter int BEAT_W     = BEAT_WORDS * WORD_WIDTH,
    parameter int DEPTH      = OUT_HEIGHT * OUT_WIDTH * FILTERS / BEAT_WORDS,
    parameter int AW         = (DEPTH > 2) ? $clog2(DEPTH) : 1
) (
    input  logic              i_aclk,
    input  logic              i_aresetn,
    input  logic              i_tvalid,
    output logic              o_tready,
    input  logic [BEAT_W-1:0] i_tdata,
    input  logic [AW-1:0]     i_rd_addr,
    output logic [BEAT_W-1:0] o_rd_data,
    output logic              o_frame_valid,
    input  logic              i_frame_ack,
    output logic [AW-1:0]     o_wr_ptr,
    output logic [15:0]       o_frame_count
);

    // A beat must never straddle two pixels.
    if (FILTERS % BEAT_WORDS != 0) begin : g_bad_beat_words
        $fatal(1, "FILTERS must be a multiple of BEAT_WORDS");
    end

    localparam logic [0:0]    ST_RECV = 1'b0;
    localparam logic [0:0]    ST_FULL = 1'b1;
    localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);
    localparam logic [AW:0]   DEPTH_W = (AW + 1)'(DEPTH);

    // Stream handshake: a beat transfers on a rising edge where i_tvalid && o_tready.
    // o_tready is registered and never looks at i_tvalid.
    logic [0:0]        state;
    logic              hs;
    logic              last_beat;
    logic [BEAT_W-1:0] mem [0:DEPTH-1];

    assign hs        = i_tvalid && o_tready;
    assign last_beat = (o_wr_ptr == LAST);

    always_ff @(posedge i_aclk or negedge i_aresetn) begin
        if (!i_aresetn) begin
            state         <= ST_RECV;
            o_tready      <= 1'b1;
            o_frame_valid <= 1'b0;
            o_wr_ptr      <= '0;
            o_frame_count <= '0;
        end else begin
            case (state)
                ST_RECV: begin
                    if (hs) begin
                        if (last_beat) begin
                            o_wr_ptr      <= '0;
                            state         <= ST_FULL;
                            o_tready      <= 1'b0;
                            o_frame_valid <= 1'b1;
                            o_frame_count <= o_frame_count + 16'd1;
                        end else begin
                            o_wr_ptr <= o_wr_ptr + AW'(1);
                        end
                    end
                end
                ST_FULL: begin
                    if (i_frame_ack) begin
                        state         <= ST_RECV;
                        o_tready      <= 1'b1;
                        o_frame_valid <= 1'b0;
                    end
                end
                default: begin
                    state         <= ST_RECV;
                    o_tready      <= 1'b1;
                    o_frame_valid <= 1'b0;
                end
            endcase
        end
    end

    // Buffer contents survive reset so the array maps onto plain RAM.
    always_ff @(posedge i_aclk) begin
        if (hs) begin
            mem[o_wr_ptr] <= i_tdata;
        end
    end

    // Read sees the pre-write contents when the same address is written this edge.
    always_ff @(posedge i_aclk or negedge i_aresetn) begin
        if (!i_aresetn) begin
            o_rd_data <= '0;
        end else if ({1'b0, i_rd_addr} < DEPTH_W) begin
            o_rd_data <= mem[i_rd_addr];
        end else begin
            o_rd_data <= '0;
        end
    end

endmodule

// File: doc/conv2d3x3_out_sink.md
Name: conv2d3x3_out_sink

Overview:
- Receive-side endpoint for the Conv2D3x3 output AXI-Stream. Each beat carries BEAT_WORDS filter results.
- Captures one complete output feature map, OUT_HEIGHT x OUT_WIDTH pixels x FILTERS channels, into an internal frame buffer.
- When the frame is complete, it stalls the stream and presents the frame to a downstream reader via a random-access read port.
- The frame is released by an acknowledge, which re-arms the block for the next image.

Parameters:
- OUT_HEIGHT, 3, output rows (IN_HEIGHT-2 for a valid 3x3 convolution)
- OUT_WIDTH, 2, output columns (IN_WIDTH-2)
- FILTERS, 8, output channels per pixel
- WORD_WIDTH, 8, bits per result word
- BEAT_WORDS, 4, words per stream beat (KERNEL_BUF_WIDTH / (WORD_WIDTH*WORDS) upstream); FILTERS % BEAT_WORDS must be 0, otherwise elaboration fails with $fatal
- Derived: BEAT_W = BEAT_WORDS*WORD_WIDTH
- Derived: DEPTH = OUT_HEIGHT*OUT_WIDTH*FILTERS/BEAT_WORDS
- Derived: AW = max(1, $clog2(DEPTH))

Ports:
- i_aclk  in  1  single clock; all logic on rising edge
- i_aresetn  in  1  asynchronous active-low reset
- i_tvalid  in  1  upstream beat valid
- o_tready  out  1  sink ready
- i_tdata  in  BEAT_W  beat; word k at [k*WORD_WIDTH +: WORD_WIDTH] is filter (beat%(FILTERS/BEAT_WORDS))*BEAT_WORDS+k
- i_rd_addr  in  AW  buffer read address (beat index)
- o_rd_data  out  BEAT_W  registered read data
- o_frame_valid  out  1  a complete frame is held in the buffer
- i_frame_ack  in  1  reader done; releases the buffer
- o_wr_ptr  out  AW  beats captured so far in the current frame
- o_frame_count  out  16  frames completed, modulo 2^16

Behaviour:
- Reset (asynchronous assert, synchronous deassert internally is not required) clears state and outputs:
  - state=RECV, o_tready=1, o_frame_valid=0, o_wr_ptr=0, o_rd_data=0, o_frame_count=0
  - Buffer contents are not cleared.
- A handshake occurs on a rising edge where i_tvalid & o_tready.
- o_tready is a registered output. It does not depend combinationally on i_tvalid.
- RECV state:
  - o_tready=1.
  - On each handshake: mem[o_wr_ptr] <= i_tdata, o_wr_ptr <= o_wr_ptr+1.
  - Handshake with o_wr_ptr==DEPTH-1 (last beat):
    - write the beat
    - o_wr_ptr <= 0
    - state <= FULL
    - o_tready <= 0 and o_frame_valid <= 1, both visible the cycle after the last handshake
    - o_frame_count <= o_frame_count+1
  - i_frame_ack is ignored in RECV.
- FULL state:
  - o_tready=0, o_frame_valid=1.
  - i_tvalid is held off by the sink. Upstream data is not lost; it stalls.
  - i_frame_ack=1 on an edge: state <= RECV, o_frame_valid <= 0, o_tready <= 1 the next cycle. A beat presented during the ack cycle is not accepted.
- Read port:
  - o_rd_data <= mem[i_rd_addr] every cycle, in any state. Latency is 1 cycle.
  - Addresses >= DEPTH return 0.
  - Reading the address being written in the same cycle returns the old contents (read-before-write).
- Pixel/filter mapping: beat b holds pixel p = b/(FILTERS/BEAT_WORDS) in raster order, row = p/OUT_WIDTH, col = p%OUT_WIDTH.
- Back-to-back beats in RECV are accepted at 1 beat/cycle with no bubbles.
- An arbitrary i_tvalid gap pattern does not alter contents or ordering.
- Reset mid-frame discards the partial frame: o_wr_ptr=0 and the next accepted beat goes to address 0.
- o_frame_count wraps from 16'hFFFF to 0.
- The buffer is a single-port-write / single-port-read array, inferable as distributed or block RAM.

Test Plan:
- Reset, then sample: o_tready=1, o_frame_valid=0, o_wr_ptr=0, o_frame_count=0, o_rd_data=0.
- Drive 12 back-to-back beats with i_tdata=32'h03020100+b*32'h04040404 ->
  - o_wr_ptr counts 0..11, then wraps to 0
  - o_tready=0 and o_frame_valid=1 the cycle after beat 11; o_frame_count=1
  - reads of addresses 0..11 return the driven values one cycle later
  - read of address 12 returns 0
- Hold i_tvalid=1 for 5 cycles in FULL with new data -> no writes; address 0 still reads 32'h03020100.
- Pulse i_frame_ack for 1 cycle -> o_frame_valid=0 and o_tready=1 next cycle. Send a second frame of all-32'h01010101 with random 0-3 cycle tvalid gaps -> o_frame_count=2 and all 12 addresses read 32'h01010101.
- Send 5 beats, assert i_aresetn=0 asynchronously mid-cycle, release it, then send 12 beats of 32'hA5A5A5A5 -> frame completes after exactly 12 beats and address 0 holds 32'hA5A5A5A5.
- Assert i_frame_ack in RECV after 3 beats -> no effect: o_wr_ptr=3 remains and the frame still completes after 9 more beats.
